// File: rtl/video_out_fetch_pkg.sv
// Shared types and constants for the video-out frame fetch path.
package video_out_pkg;

  typedef enum logic [1:0] {
    WAIT_ADDR = 2'd0,
    WAIT_ROOM = 2'd1,
    READ      = 2'd2,
    FRAME_END = 2'd3
  } state_t;

  localparam int FRAME_WORDS = 640 * 480 / 4;
  localparam int WCNT_W      = $clog2(FRAME_WORDS + 1);
  localparam logic [3:0] WB_SEL = 4'hf;

  function automatic int frame_words(input int width, input int height);
    return width * height / 4;
  endfunction

endpackage

// File: rtl/video_out_fetch.sv
// Wishbone read master: fetches one stored frame from RAM in FIFO-gated
// bursts and pushes it into the video-out FIFO, then pulses frame-done.
module video_out_fetch
  import video_out_pkg::*;
#(
  parameter int p_WIDTH  = 640,
  parameter int p_HEIGHT = 480,
  parameter int BURST    = 16,
  parameter int IRQ_LEN  = 3
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] wb_reg_ctr,
  input  logic [31:0] wb_reg_data,
  input  logic [7:0]  fifo_room,
  output logic        fifo_wr,
  output logic [31:0] fifo_data,
  output logic        interrupt,
  output logic        bus_error,
  output logic        p_wb_CYC_O,
  output logic        p_wb_STB_O,
  output logic        p_wb_LOCK_O,
  output logic        p_wb_WE_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic [31:0] p_wb_ADR_O,
  input  logic [31:0] p_wb_DAT_I,
  input  logic        p_wb_ACK_I,
  input  logic        p_wb_ERR_I
);

  localparam int LP_FRAME_WORDS = frame_words(p_WIDTH, p_HEIGHT);
  localparam int BCNT_W = $clog2(BURST + 1);
  localparam int IRQ_W  = $clog2(IRQ_LEN + 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(LP_FRAME_WORDS - 1);
  localparam logic [BCNT_W-1:0] BURST_LEN = BCNT_W'(BURST);
  localparam logic [IRQ_W-1:0]  IRQ_LAST  = IRQ_W'(IRQ_LEN - 1);

  state_t             state;
  logic               ctr0_q;
  logic               new_addr;
  logic [31:0]        addr_in;
  logic [31:0]        base;
  logic [31:0]        pending_base;
  logic               pending;
  logic [WCNT_W-1:0]  word_cnt;
  logic [BCNT_W-1:0]  burst_cnt;
  logic [IRQ_W-1:0]   irq_cnt;
  logic               resp;
  logic               unused_bits;

  assign new_addr = wb_reg_ctr[0] & ~ctr0_q;
  assign addr_in  = {wb_reg_data[31:2], 2'b00};
  // ACK together with ERR is treated as ERR; responses outside READ are dropped.
  assign resp     = (state == READ) & p_wb_STB_O & (p_wb_ACK_I | p_wb_ERR_I);

  assign p_wb_LOCK_O = 1'b0;
  assign p_wb_WE_O   = 1'b0;
  assign p_wb_SEL_O  = WB_SEL;
  assign unused_bits = ^{wb_reg_ctr[31:1], wb_reg_data[1:0]};

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state        <= WAIT_ADDR;
      ctr0_q       <= 1'b0;
      base         <= '0;
      pending_base <= '0;
      pending      <= 1'b0;
      word_cnt     <= '0;
      burst_cnt    <= '0;
      irq_cnt      <= '0;
      fifo_wr      <= 1'b0;
      fifo_data    <= '0;
      interrupt    <= 1'b0;
      bus_error    <= 1'b0;
      p_wb_CYC_O   <= 1'b0;
      p_wb_STB_O   <= 1'b0;
      p_wb_ADR_O   <= '0;
    end else begin
      ctr0_q  <= wb_reg_ctr[0];
      fifo_wr <= 1'b0;
      case (state)
        WAIT_ADDR: begin
          if (new_addr) begin
            base      <= addr_in;
            word_cnt  <= '0;
            bus_error <= 1'b0;
            state     <= WAIT_ROOM;
          end
        end
        WAIT_ROOM: begin
          if ({24'd0, fifo_room} >= 32'(BURST)) begin
            burst_cnt  <= BURST_LEN;
            p_wb_ADR_O <= base + 32'({word_cnt, 2'b00});
            p_wb_CYC_O <= 1'b1;
            p_wb_STB_O <= 1'b1;
            state      <= READ;
          end
        end
        READ: begin
          if (resp) begin
            fifo_wr    <= 1'b1;
            fifo_data  <= p_wb_ERR_I ? '0 : p_wb_DAT_I;
            if (p_wb_ERR_I) bus_error <= 1'b1;
            word_cnt   <= word_cnt + WCNT_W'(1);
            burst_cnt  <= burst_cnt - BCNT_W'(1);
            p_wb_ADR_O <= p_wb_ADR_O + 32'd4;
            if (burst_cnt == BCNT_W'(1)) begin
              p_wb_CYC_O <= 1'b0;
              p_wb_STB_O <= 1'b0;
              if (word_cnt == LAST_WORD) begin
                state     <= FRAME_END;
                interrupt <= 1'b1;
                irq_cnt   <= '0;
              end else begin
                state <= WAIT_ROOM;
              end
            end
          end
        end
        FRAME_END: begin
          irq_cnt <= irq_cnt + IRQ_W'(1);
          if (irq_cnt == IRQ_LAST) begin
            interrupt <= 1'b0;
            if (pending) begin
              base      <= pending_base;
              pending   <= 1'b0;
              word_cnt  <= '0;
              bus_error <= 1'b0;
              state     <= WAIT_ROOM;
            end else begin
              state <= WAIT_ADDR;
            end
          end
        end
        default: state <= WAIT_ADDR;
      endcase
      // Placed after the case so an edge coinciding with the pending hand-over is kept.
      if (new_addr && state != WAIT_ADDR) begin
        pending_base <= addr_in;
        pending      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_out_fetch.sv
// Bench for video_out_fetch: a Wishbone slave with random data and wait
// states feeds a scoreboard; addresses and FIFO words are checked per frame.
module tb_video_out_fetch;
  localparam int TW   = 64;
  localparam int TH   = 4;
  localparam int TB   = 16;
  localparam int TIRQ = 3;
  localparam int FW   = TW * TH / 4;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] wb_reg_ctr = '0;
  logic [31:0] wb_reg_data = '0;
  logic [7:0]  fifo_room = '0;
  logic        fifo_wr, interrupt, bus_error;
  logic [31:0] fifo_data;
  logic        cyc, stb, lock, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack, err;

  int checks = 0;
  int errors = 0;

  // slave configuration (written by tasks only)
  logic spur_ack = 1'b0;
  logic err_both = 1'b0;
  logic rand_delay = 1'b0;
  int   ack_delay = 0;
  int   err_idx = -1;
  // slave state (written by the slave process only)
  int          wait_q = 0;
  int          cur_delay = 0;
  int          resp_cnt = 0;
  int          hold_viol = 0;
  logic [31:0] hold_adr = '0;
  logic [31:0] dat_cur = 32'h1234_5678;
  logic [31:0] adr_log[$];
  logic [31:0] exp_q[$];
  logic [31:0] wr_log[$];

  logic ready, is_err;
  assign ready  = cyc & stb & (wait_q >= cur_delay);
  assign is_err = ready & (resp_cnt == err_idx);
  assign err    = is_err;
  assign ack    = spur_ack | (ready & (~is_err | err_both));
  assign dat_i  = dat_cur;

  video_out_fetch #(.p_WIDTH(TW), .p_HEIGHT(TH), .BURST(TB), .IRQ_LEN(TIRQ)) dut (
    .clk(clk), .nRST(nRST), .wb_reg_ctr(wb_reg_ctr), .wb_reg_data(wb_reg_data),
    .fifo_room(fifo_room), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
    .interrupt(interrupt), .bus_error(bus_error),
    .p_wb_CYC_O(cyc), .p_wb_STB_O(stb), .p_wb_LOCK_O(lock), .p_wb_WE_O(we),
    .p_wb_SEL_O(sel), .p_wb_ADR_O(adr), .p_wb_DAT_I(dat_i),
    .p_wb_ACK_I(ack), .p_wb_ERR_I(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cyc && stb) begin
      if (ready) begin
        adr_log.push_back(adr);
        exp_q.push_back(is_err ? 32'h0 : dat_cur);
        resp_cnt  <= resp_cnt + 1;
        wait_q    <= 0;
        dat_cur   <= $urandom;
        cur_delay <= rand_delay ? int'($urandom_range(0, 2)) : ack_delay;
      end else begin
        wait_q <= wait_q + 1;
        if (wait_q > 0 && adr != hold_adr) hold_viol <= hold_viol + 1;
      end
      hold_adr <= adr;
    end else begin
      wait_q    <= 0;
      cur_delay <= rand_delay ? int'($urandom_range(0, 2)) : ack_delay;
    end
  end

  always @(negedge clk) if (fifo_wr) wr_log.push_back(fifo_data);

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_edge(input logic [31:0] a);
    wb_reg_data   = a;
    wb_reg_ctr[0] = 1'b1;
    step();
    wb_reg_ctr[0] = 1'b0;
  endtask

  int frame_a0 = 0;

  task automatic test_reset();
    int w0;
    nRST = 1'b0;
    repeat (3) step();
    checks++; if (cyc !== 1'b0 || stb !== 1'b0 || fifo_wr !== 1'b0) begin errors++; $display("FAIL reset_held: cyc=%b stb=%b wr=%b want 0", cyc, stb, fifo_wr); end
    nRST = 1'b1;
    spur_ack = 1'b1;
    w0 = wr_log.size();
    repeat (10) step();
    spur_ack = 1'b0;
    checks++; if ({cyc, stb, we, lock} !== 4'b0000) begin errors++; $display("FAIL idle_ctrl: got %b want 0000", {cyc, stb, we, lock}); end
    checks++; if (adr !== 32'h0) begin errors++; $display("FAIL idle_adr: got %h want 0", adr); end
    checks++; if (sel !== 4'hf) begin errors++; $display("FAIL idle_sel: got %h want f", sel); end
    checks++; if ({fifo_wr, interrupt, bus_error} !== 3'b000) begin errors++; $display("FAIL idle_out: got %b want 000", {fifo_wr, interrupt, bus_error}); end
    checks++; if (wr_log.size() != w0) begin errors++; $display("FAIL idle_spurious_ack: got %0d writes want 0", wr_log.size() - w0); end
  endtask

  task automatic test_first_burst();
    int a0, w0, n;
    fifo_room = 8'd16;
    a0 = adr_log.size(); w0 = wr_log.size(); frame_a0 = a0;
    start_edge(32'h0000_1003);
    checks++; if (stb !== 1'b0) begin errors++; $display("FAIL latency_early: stb=%b want 0", stb); end
    step();
    checks++; if (stb !== 1'b1 || adr !== 32'h1000) begin errors++; $display("FAIL latency_first: stb=%b adr=%h want 1/00001000", stb, adr); end
    n = 0;
    while (adr_log.size() < a0 + TB && n < 200) begin step(); n++; end
    checks++; if (adr_log.size() != a0 + TB) begin errors++; $display("FAIL burst1_timeout: got %0d want %0d", adr_log.size() - a0, TB); end
    checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin errors++; $display("FAIL burst1_drop: cyc=%b stb=%b want 0", cyc, stb); end
    fifo_room = 8'd0;
    repeat (3) step();
    checks++; if (wr_log.size() != w0 + TB) begin errors++; $display("FAIL burst1_writes: got %0d want %0d", wr_log.size() - w0, TB); end
    for (int i = 0; i < TB; i++) begin
      checks++; if (adr_log[a0 + i] !== 32'h1000 + 32'(4 * i)) begin errors++; $display("FAIL burst1_adr[%0d]: got %h want %h", i, adr_log[a0 + i], 32'h1000 + 32'(4 * i)); end
      checks++; if (wr_log[w0 + i] !== exp_q[a0 + i]) begin errors++; $display("FAIL burst1_data[%0d]: got %h want %h", i, wr_log[w0 + i], exp_q[a0 + i]); end
    end
  endtask

  task automatic test_room_gate();
    int viol, a0, n;
    fifo_room = 8'd15;
    viol = 0;
    repeat (50) begin step(); if (stb) viol++; end
    checks++; if (viol != 0) begin errors++; $display("FAIL room15_stb: got %0d strobes want 0", viol); end
    a0 = adr_log.size();
    fifo_room = 8'd16;
    step();
    checks++; if (stb !== 1'b1 || adr !== 32'h1040) begin errors++; $display("FAIL room16_start: stb=%b adr=%h want 1/00001040", stb, adr); end
    n = 0;
    while (adr_log.size() < a0 + TB && n < 200) begin step(); n++; end
    fifo_room = 8'd0;
    checks++; if (adr_log.size() != a0 + TB) begin errors++; $display("FAIL burst2_timeout: got %0d want %0d", adr_log.size() - a0, TB); end
    repeat (2) step();
  endtask

  task automatic test_wait_err();
    int a0, w0, h0, n;
    ack_delay = 3; err_both = 1'b1;
    a0 = adr_log.size(); w0 = wr_log.size(); h0 = hold_viol;
    err_idx = resp_cnt + 5;
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL err_before: got %b want 0", bus_error); end
    fifo_room = 8'd16;
    n = 0;
    while (adr_log.size() < a0 + TB && n < 300) begin step(); n++; end
    fifo_room = 8'd0;
    repeat (3) step();
    checks++; if (adr_log.size() != a0 + TB) begin errors++; $display("FAIL burst3_timeout: got %0d want %0d", adr_log.size() - a0, TB); end
    checks++; if (hold_viol != h0) begin errors++; $display("FAIL wait_hold: got %0d changes want 0", hold_viol - h0); end
    checks++; if (wr_log.size() != w0 + TB) begin errors++; $display("FAIL burst3_writes: got %0d want %0d", wr_log.size() - w0, TB); end
    checks++; if (wr_log[w0 + 5] !== 32'h0) begin errors++; $display("FAIL err_word_data: got %h want 0", wr_log[w0 + 5]); end
    checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", bus_error); end
    for (int i = 0; i < TB; i++) begin
      checks++; if (adr_log[a0 + i] !== 32'h1080 + 32'(4 * i)) begin errors++; $display("FAIL burst3_adr[%0d]: got %h want %h", i, adr_log[a0 + i], 32'h1080 + 32'(4 * i)); end
      checks++; if (wr_log[w0 + i] !== exp_q[a0 + i]) begin errors++; $display("FAIL burst3_data[%0d]: got %h want %h", i, wr_log[w0 + i], exp_q[a0 + i]); end
    end
    ack_delay = 0; err_both = 1'b0; err_idx = -1;
  endtask

  task automatic test_frame_end();
    int n, irq, strobes, a_end;
    fifo_room = 8'd255;
    n = 0;
    while (adr_log.size() < frame_a0 + FW && n < 500) begin step(); n++; end
    checks++; if (adr_log.size() != frame_a0 + FW) begin errors++; $display("FAIL frame1_timeout: got %0d want %0d", adr_log.size() - frame_a0, FW); end
    checks++; if (adr_log[frame_a0 + FW - 1] !== 32'h1000 + 32'(4 * (FW - 1))) begin errors++; $display("FAIL frame1_last_adr: got %h want %h", adr_log[frame_a0 + FW - 1], 32'h1000 + 32'(4 * (FW - 1))); end
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_start: got %b want 1", interrupt); end
    irq = 0; strobes = 0; a_end = adr_log.size();
    repeat (30) begin if (interrupt) irq++; if (stb) strobes++; step(); end
    checks++; if (irq != TIRQ) begin errors++; $display("FAIL irq_len: got %0d want %0d", irq, TIRQ); end
    checks++; if (strobes != 0 || adr_log.size() != a_end) begin errors++; $display("FAIL after_frame_idle: got %0d strobes want 0", strobes); end
    checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL err_kept_to_frame_end: got %b want 1", bus_error); end
  endtask

  task automatic test_wrap_random();
    logic [31:0] raw, b;
    int a0, w0, n, irq;
    raw = 32'hFFFF_FF00 | ($urandom & 32'h0000_00FF);
    b = raw & 32'hFFFF_FFFC;
    rand_delay = 1'b1;
    a0 = adr_log.size(); w0 = wr_log.size();
    start_edge(raw);
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL err_clear_on_new: got %b want 0", bus_error); end
    n = 0; irq = 0;
    while (adr_log.size() < a0 + FW && n < 1000) begin step(); n++; end
    repeat (12) begin if (interrupt) irq++; step(); end
    rand_delay = 1'b0;
    checks++; if (adr_log.size() != a0 + FW) begin errors++; $display("FAIL wrap_timeout: got %0d want %0d", adr_log.size() - a0, FW); end
    checks++; if (irq != TIRQ) begin errors++; $display("FAIL wrap_irq_len: got %0d want %0d", irq, TIRQ); end
    checks++; if (wr_log.size() != w0 + FW) begin errors++; $display("FAIL wrap_writes: got %0d want %0d", wr_log.size() - w0, FW); end
    for (int i = 0; i < FW; i++) begin
      checks++; if (adr_log[a0 + i] !== b + 32'(4 * i)) begin errors++; $display("FAIL wrap_adr[%0d]: got %h want %h", i, adr_log[a0 + i], b + 32'(4 * i)); end
      checks++; if (wr_log[w0 + i] !== exp_q[a0 + i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, wr_log[w0 + i], exp_q[a0 + i]); end
    end
  endtask

  task automatic test_pending();
    logic [31:0] b1;
    int a0, n, irq, a_end, strobes;
    b1 = $urandom & 32'h0FFF_FFF0;
    rand_delay = 1'b1;
    a0 = adr_log.size();
    start_edge(b1);
    n = 0;
    while (adr_log.size() < a0 + 20 && n < 300) begin step(); n++; end
    start_edge(32'h0000_2000);
    n = 0; irq = 0;
    while (adr_log.size() < a0 + 2 * FW && n < 2000) begin if (interrupt) irq++; step(); n++; end
    repeat (12) begin if (interrupt) irq++; step(); end
    rand_delay = 1'b0;
    checks++; if (adr_log.size() != a0 + 2 * FW) begin errors++; $display("FAIL pend_timeout: got %0d want %0d", adr_log.size() - a0, 2 * FW); end
    checks++; if (irq != 2 * TIRQ) begin errors++; $display("FAIL pend_irq: got %0d want %0d", irq, 2 * TIRQ); end
    for (int i = 0; i < FW; i++) begin
      checks++; if (adr_log[a0 + i] !== b1 + 32'(4 * i)) begin errors++; $display("FAIL pend_f1_adr[%0d]: got %h want %h", i, adr_log[a0 + i], b1 + 32'(4 * i)); end
      checks++; if (adr_log[a0 + FW + i] !== 32'h2000 + 32'(4 * i)) begin errors++; $display("FAIL pend_f2_adr[%0d]: got %h want %h", i, adr_log[a0 + FW + i], 32'h2000 + 32'(4 * i)); end
    end
    a_end = adr_log.size(); strobes = 0;
    repeat (30) begin if (stb) strobes++; step(); end
    checks++; if (strobes != 0 || adr_log.size() != a_end) begin errors++; $display("FAIL pend_once: got %0d strobes want 0", strobes); end
  endtask

  task automatic test_reset_mid();
    int a0, n, w0, strobes;
    a0 = adr_log.size();
    start_edge(32'h0000_5000);
    n = 0;
    while (adr_log.size() < a0 + 10 && n < 300) begin step(); n++; end
    start_edge(32'h0000_3000);
    n = 0;
    while (adr_log.size() < a0 + 20 && n < 300) begin step(); n++; end
    checks++; if (stb !== 1'b1) begin errors++; $display("FAIL mid_burst_pre: stb=%b want 1", stb); end
    w0 = wr_log.size();
    nRST = 1'b0;
    #1;
    checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin errors++; $display("FAIL async_release: cyc=%b stb=%b want 0", cyc, stb); end
    repeat (3) step();
    nRST = 1'b1;
    strobes = 0;
    repeat (60) begin if (stb) strobes++; step(); end
    checks++; if (strobes != 0) begin errors++; $display("FAIL pending_lost: got %0d strobes want 0", strobes); end
    checks++; if (wr_log.size() != w0) begin errors++; $display("FAIL reset_no_wr: got %0d writes want 0", wr_log.size() - w0); end
    start_edge(32'h0000_6000);
    step();
    checks++; if (stb !== 1'b1 || adr !== 32'h6000) begin errors++; $display("FAIL restart_after_reset: stb=%b adr=%h want 1/00006000", stb, adr); end
  endtask

  initial begin
    test_reset();
    test_first_burst();
    test_room_gate();
    test_wait_err();
    test_frame_end();
    test_wrap_random();
    test_pending();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/video_out_fetch.md
Name: video_out_fetch

Overview:
- Wishbone master that reads one stored frame from RAM and streams it as 32-bit words (4 pixels/word) into the video-out FIFO.
- Mirror of the video-in store path: the processor writes a frame base address and toggles a control bit; the block fetches the frame in bursts gated by FIFO room.
- Raises a frame-done interrupt after the last word is pushed.

Parameters:
- p_WIDTH, 640, pixels per line.
- p_HEIGHT, 480, lines per frame.
- BURST, 16, 32-bit words read per burst; p_WIDTH*p_HEIGHT/4 must be a multiple of BURST.
- IRQ_LEN, 3, interrupt pulse length in cycles (minimum 3).

Ports:
- clk  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- wb_reg_ctr  in  32  processor control register; a rising edge of bit 0 means a new base address is valid.
- wb_reg_data  in  32  frame base byte address.
- fifo_room  in  8  free word slots in the output FIFO.
- fifo_wr  out  1  write strobe into the FIFO.
- fifo_data  out  32  word written into the FIFO.
- interrupt  out  1  frame done, high for IRQ_LEN cycles.
- bus_error  out  1  sticky: an ERR_I was seen in the current frame.
- p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, p_wb_WE_O  out  1 each  Wishbone master controls.
- p_wb_SEL_O  out  4  constant 4'hf.
- p_wb_ADR_O  out  32  byte address.
- p_wb_DAT_I  in  32  read data.
- p_wb_ACK_I, p_wb_ERR_I  in  1 each  slave response.

Behaviour:
- Reset: all outputs 0 except SEL = 4'hf. Internal state: state = WAIT_ADDR, word counter = 0, pending flag = 0.
- new_addr = rising edge of wb_reg_ctr[0], using a registered previous value.
  - In WAIT_ADDR: latch base = {wb_reg_data[31:2], 2'b00}.
  - In any other state: store the value in pending_base and set the pending flag. A later edge overwrites it.
- States:
  - WAIT_ADDR: wait for new_addr. On new_addr go to WAIT_ROOM; clear the word counter and bus_error.
  - WAIT_ROOM: CYC = STB = 0. When fifo_room >= BURST, go to READ and reset the burst counter to BURST.
  - READ: CYC = STB = 1, WE = 0, LOCK = 0, ADR = base + 4*word_cnt. Hold these until ACK_I or ERR_I.
    - On the response cycle, register fifo_data = DAT_I (or 0 on ERR_I) and pulse fifo_wr the next cycle.
    - On ERR_I, also set bus_error.
    - Increment word_cnt and decrement the burst counter.
    - If the burst counter reaches 0: drop CYC/STB the following cycle. Go to FRAME_END if word_cnt == p_WIDTH*p_HEIGHT/4, otherwise to WAIT_ROOM.
    - Otherwise stay in READ; ADR advances by 4 the cycle after the response while CYC and STB stay high.
  - FRAME_END: interrupt = 1 for IRQ_LEN cycles (internal counter), CYC = STB = 0. Then:
    - if pending: base = pending_base, clear pending, clear word_cnt and bus_error, go to WAIT_ROOM;
    - otherwise go to WAIT_ADDR.
- ACK_I and ERR_I asserted together count as ERR.
- Responses outside READ are ignored.
- word_cnt is 17 bits (76800 words).
- Address arithmetic is 32-bit and wraps modulo 2^32 with no check.
- fifo_room drops during a burst: no effect. Room is checked only at burst start, and the FIFO owner guarantees the reserved slots.
- nRST asserted mid-burst: bus released immediately, no fifo_wr, any pending base is lost.
- Latency: first STB 1 cycle after the new_addr edge is detected, provided room is available.

Decomposition:
- Package video_out_pkg:
  - state enum {WAIT_ADDR, WAIT_ROOM, READ, FRAME_END};
  - constant FRAME_WORDS = p_WIDTH*p_HEIGHT/4;
  - Wishbone SEL constant.
- No sub-module required; the edge detector and IRQ timer stay inline.

Test Plan:
- Reset, then idle 10 cycles -> all Wishbone outputs 0, SEL = f, fifo_wr = 0, interrupt = 0.
- ctr[0] 0->1 with data = 0x0000_1003, fifo_room = 16, zero-wait ACK -> 16 reads at ADR 0x1000..0x103C, 16 fifo_wr pulses carrying the DAT_I values in order, then CYC drops.
- fifo_room = 15 after the address -> no STB for 50 cycles; room -> 16 -> burst starts next cycle.
- ACK delayed 3 cycles per word; ERR_I on word 5 -> ADR/STB held stable while waiting, fifo_data = 0 for word 5, bus_error = 1, burst completes with 16 writes.
- Full frame with fifo_room = 255 -> exactly 76800 fifo_wr pulses, last ADR = base + 0x4AFFC, interrupt high exactly 3 cycles, then WAIT_ADDR.
- New address 0x2000 edge mid-frame, then nRST mid-burst in a second run:
  - first run: after the interrupt the next frame starts at 0x2000 without a new edge;
  - second run: CYC = 0 asynchronously and no pending frame fetched afterwards.
